// File: rtl/piece_move_ctrl_if.sv
// Shared types and the request/board/response bundle for piece_move_ctrl.
// Latency: none; this file holds only declarations and wiring.
// Backpressure: spawn_ready and cmd_ready, driven by the slave side.
//
// piece_pkg: piece type, rotation, committed-piece struct and the 4x4 occupancy grid.
// piece_move_ctrl_if ports:
//   master = requesters plus board RAM: spawn/cmd requests and board_row_data
//   slave  = piece_move_ctrl: readies, board_row_addr, piece state and response pulses
package piece_pkg;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_type_t;

  typedef enum logic [1:0] {
    ROT_0   = 2'd0,
    ROT_90  = 2'd1,
    ROT_180 = 2'd2,
    ROT_270 = 2'd3
  } rot_t;

  typedef struct packed {
    piece_type_t       ptype;
    rot_t              rot;
    logic signed [4:0] x;
    logic signed [5:0] y;
  } active_piece_t;

  // piece[r] bit c marks the cell at column x+c, row y+r
  typedef struct packed {
    logic [3:0][3:0] piece;
  } piece_grid_t;

endpackage

interface piece_move_ctrl_if #(
  parameter int BOARD_W = 10
);
  import piece_pkg::*;

  logic                 spawn_valid;
  piece_type_t          spawn_type;
  logic                 spawn_ready;
  logic                 cmd_valid;
  logic [2:0]           cmd;
  logic                 cmd_ready;
  logic [4:0]           board_row_addr;
  logic [BOARD_W-1:0]   board_row_data;
  active_piece_t        active_piece;
  logic                 piece_valid;
  logic                 resp_valid;
  logic                 resp_accepted;
  logic                 lock_pulse;
  logic                 game_over;

  modport master (
    output spawn_valid, spawn_type, cmd_valid, cmd, board_row_data,
    input  spawn_ready, cmd_ready, board_row_addr, active_piece, piece_valid,
           resp_valid, resp_accepted, lock_pulse, game_over
  );

  modport slave (
    input  spawn_valid, spawn_type, cmd_valid, cmd, board_row_data,
    output spawn_ready, cmd_ready, board_row_addr, active_piece, piece_valid,
           resp_valid, resp_accepted, lock_pulse, game_over
  );

endinterface

// File: rtl/piece_move_ctrl.sv
// Owns the falling piece and runs each spawn/move candidate through a 4-row board collision check.
// Latency: 6 cycles from the accept edge to resp_valid, then 1 idle cycle before the next accept.
// Backpressure: spawn_ready/cmd_ready are low while a request is in flight; one request at a time.
//
// Ports: clk, reset (async, active-high), bus (piece_move_ctrl_if.slave).
// piece_decoder: combinational type+rotation -> 4x4 occupancy grid.
module piece_decoder
  import piece_pkg::*;
(
  input  active_piece_t piece,
  output piece_grid_t   grid
);

  // Each entry is {row3,row2,row1,row0}; within a row, bit c is column offset c
  logic [15:0] bits;

  always_comb begin
    bits = 16'h0000;
    case ({piece.ptype, piece.rot})
      {PIECE_I, ROT_0}:   bits = 16'h00F0;
      {PIECE_I, ROT_90}:  bits = 16'h4444;
      {PIECE_I, ROT_180}: bits = 16'h0F00;
      {PIECE_I, ROT_270}: bits = 16'h2222;
      {PIECE_O, ROT_0}, {PIECE_O, ROT_90},
      {PIECE_O, ROT_180}, {PIECE_O, ROT_270}: bits = 16'h0066;
      {PIECE_T, ROT_0}:   bits = 16'h0072;
      {PIECE_T, ROT_90}:  bits = 16'h0262;
      {PIECE_T, ROT_180}: bits = 16'h0270;
      {PIECE_T, ROT_270}: bits = 16'h0232;
      {PIECE_S, ROT_0}:   bits = 16'h0036;
      {PIECE_S, ROT_90}:  bits = 16'h0462;
      {PIECE_S, ROT_180}: bits = 16'h0360;
      {PIECE_S, ROT_270}: bits = 16'h0231;
      {PIECE_Z, ROT_0}:   bits = 16'h0063;
      {PIECE_Z, ROT_90}:  bits = 16'h0264;
      {PIECE_Z, ROT_180}: bits = 16'h0630;
      {PIECE_Z, ROT_270}: bits = 16'h0132;
      {PIECE_J, ROT_0}:   bits = 16'h0071;
      {PIECE_J, ROT_90}:  bits = 16'h0226;
      {PIECE_J, ROT_180}: bits = 16'h0470;
      {PIECE_J, ROT_270}: bits = 16'h0322;
      {PIECE_L, ROT_0}:   bits = 16'h0074;
      {PIECE_L, ROT_90}:  bits = 16'h0622;
      {PIECE_L, ROT_180}: bits = 16'h0170;
      {PIECE_L, ROT_270}: bits = 16'h0223;
      default:            bits = 16'h0000;
    endcase
  end

  assign grid = bits;

endmodule

module piece_move_ctrl
  import piece_pkg::*;
#(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20
) (
  input logic              clk,
  input logic              reset,
  piece_move_ctrl_if.slave bus
);

  localparam int CW = $clog2(BOARD_W);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CHK0 = 3'd1;
  localparam logic [2:0] S_CHK1 = 3'd2;
  localparam logic [2:0] S_CHK2 = 3'd3;
  localparam logic [2:0] S_CHK3 = 3'd4;
  localparam logic [2:0] S_CHK4 = 3'd5;
  localparam logic [2:0] S_RESP = 3'd6;

  localparam logic [2:0] CMD_LEFT    = 3'd0;
  localparam logic [2:0] CMD_RIGHT   = 3'd1;
  localparam logic [2:0] CMD_DOWN    = 3'd2;
  localparam logic [2:0] CMD_ROT_CW  = 3'd3;
  localparam logic [2:0] CMD_ROT_CCW = 3'd4;

  logic [2:0]    state;
  active_piece_t active_q;
  active_piece_t cand;
  active_piece_t next_cand;
  piece_grid_t   cand_grid;
  logic [2:0]    cmd_q;
  logic          is_spawn_q;
  logic          coll_q;
  logic          coll_total;
  logic          piece_valid_q;
  logic          resp_valid_q;
  logic          resp_acc_q;
  logic          lock_q;
  logic          go_q;

  logic          spawn_fire;
  logic          cmd_fire;
  logic          rd_en;
  logic [1:0]    rd_k;
  logic          ev_en;
  logic [1:0]    ev_k;
  logic          row_hit;
  logic [3:0]    row_bits;
  int            row_y;
  int            col;
  logic [CW-1:0] col_idx;

  assign bus.spawn_ready   = (state == S_IDLE) && !piece_valid_q;
  assign bus.cmd_ready     = (state == S_IDLE) && piece_valid_q;
  assign bus.active_piece  = active_q;
  assign bus.piece_valid   = piece_valid_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_accepted = resp_acc_q;
  assign bus.lock_pulse    = lock_q;
  assign bus.game_over     = go_q;

  assign spawn_fire = bus.spawn_valid && bus.spawn_ready;
  assign cmd_fire   = bus.cmd_valid && bus.cmd_ready;

  piece_decoder u_dec (
    .piece (cand),
    .grid  (cand_grid)
  );

  // Reserved commands keep the current piece as the candidate; they are
  // rejected via the preset collision flag, not via the board check.
  always_comb begin
    next_cand = active_q;
    if (spawn_fire) begin
      next_cand = '{ptype: bus.spawn_type, rot: ROT_0,
                    x: 5'(BOARD_W / 2 - 2), y: 6'sd0};
    end else begin
      case (bus.cmd)
        CMD_LEFT:    next_cand.x   = active_q.x - 5'sd1;
        CMD_RIGHT:   next_cand.x   = active_q.x + 5'sd1;
        CMD_DOWN:    next_cand.y   = active_q.y + 6'sd1;
        CMD_ROT_CW:  next_cand.rot = rot_t'(active_q.rot + 2'd1);
        CMD_ROT_CCW: next_cand.rot = rot_t'(active_q.rot - 2'd1);
        default:     next_cand     = active_q;
      endcase
    end
  end

  // Row k is addressed in CHKk; the RAM answers one cycle later, in CHK(k+1).
  always_comb begin
    rd_en = 1'b0;
    rd_k  = 2'd0;
    ev_en = 1'b0;
    ev_k  = 2'd0;
    case (state)
      S_CHK0: begin rd_en = 1'b1; rd_k = 2'd0; end
      S_CHK1: begin rd_en = 1'b1; rd_k = 2'd1; ev_en = 1'b1; ev_k = 2'd0; end
      S_CHK2: begin rd_en = 1'b1; rd_k = 2'd2; ev_en = 1'b1; ev_k = 2'd1; end
      S_CHK3: begin rd_en = 1'b1; rd_k = 2'd3; ev_en = 1'b1; ev_k = 2'd2; end
      S_CHK4: begin ev_en = 1'b1; ev_k = 2'd3; end
      default: ;
    endcase
  end

  assign bus.board_row_addr = rd_en ? (cand.y[4:0] + {3'b000, rd_k}) : 5'd0;

  // Cells above the board never collide; cells below it or off either side
  // always do; otherwise the board bit decides.
  always_comb begin
    row_hit  = 1'b0;
    col      = 0;
    col_idx  = '0;
    row_bits = cand_grid.piece[ev_k];
    row_y    = int'(cand.y) + int'(ev_k);
    if (ev_en && (row_bits != 4'h0) && (row_y >= 0)) begin
      if (row_y >= BOARD_H) begin
        row_hit = 1'b1;
      end else begin
        for (int c = 0; c < 4; c++) begin
          if (row_bits[c]) begin
            col = int'(cand.x) + c;
            if ((col < 0) || (col >= BOARD_W)) begin
              row_hit = 1'b1;
            end else begin
              col_idx = CW'(col);
              if (bus.board_row_data[col_idx]) row_hit = 1'b1;
            end
          end
        end
      end
    end
  end

  assign coll_total = coll_q | row_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      active_q      <= '0;
      cand          <= '0;
      cmd_q         <= 3'd0;
      is_spawn_q    <= 1'b0;
      coll_q        <= 1'b0;
      piece_valid_q <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_acc_q    <= 1'b0;
      lock_q        <= 1'b0;
      go_q          <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_acc_q   <= 1'b0;
      lock_q       <= 1'b0;
      go_q         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (spawn_fire || cmd_fire) begin
            cand       <= next_cand;
            is_spawn_q <= spawn_fire;
            cmd_q      <= bus.cmd;
            coll_q     <= cmd_fire && (bus.cmd > CMD_ROT_CCW);
            state      <= S_CHK0;
          end
        end
        S_CHK0: state <= S_CHK1;
        S_CHK1: begin coll_q <= coll_total; state <= S_CHK2; end
        S_CHK2: begin coll_q <= coll_total; state <= S_CHK3; end
        S_CHK3: begin coll_q <= coll_total; state <= S_CHK4; end
        S_CHK4: begin
          state        <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_acc_q   <= !coll_total;
          lock_q       <= coll_total && !is_spawn_q && (cmd_q == CMD_DOWN);
          go_q         <= coll_total && is_spawn_q;
          if (!coll_total) begin
            active_q <= cand;
            if (is_spawn_q) piece_valid_q <= 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          // A rejected DOWN locks the piece: hand it to the lock logic.
          if (lock_q) piece_valid_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_move_ctrl.sv
module tb_piece_move_ctrl;
  import piece_pkg::*;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  piece_move_ctrl_if #(.BOARD_W(BOARD_W)) bus ();

  piece_move_ctrl #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous board RAM; out-of-range addresses return garbage.
  logic [BOARD_W-1:0] board [BOARD_H];
  always @(posedge clk)
    bus.board_row_data <= (bus.board_row_addr < BOARD_H) ?
                          board[bus.board_row_addr] : BOARD_W'($urandom);

  // Reference piece state
  int m_type, m_rot, m_x, m_y;
  bit m_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  // Shapes at ROT_0 as (row, col) cells in their bounding box; I uses a 4x4
  // box, O does not rotate, everything else rotates in a 3x3 box.
  int base_r [7][4] = '{'{1,1,1,1}, '{0,0,1,1}, '{0,1,1,1}, '{0,0,1,1},
                        '{0,0,1,1}, '{0,1,1,1}, '{0,1,1,1}};
  int base_c [7][4] = '{'{0,1,2,3}, '{1,2,1,2}, '{1,0,1,2}, '{1,2,0,1},
                        '{0,1,1,2}, '{0,0,1,2}, '{2,0,1,2}};

  task automatic chk(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit model_collide(int t, int rot, int x, int y);
    int r, c, nr, n, row, colm;
    n = (t == 0) ? 4 : 3;
    for (int i = 0; i < 4; i++) begin
      r = base_r[t][i];
      c = base_c[t][i];
      if (t != 1) begin
        for (int k = 0; k < rot; k++) begin
          nr = c;
          c  = n - 1 - r;
          r  = nr;
        end
      end
      row  = y + r;
      colm = x + c;
      if (row < 0) continue;
      if (colm < 0 || colm >= BOARD_W || row >= BOARD_H) return 1'b1;
      if (board[row][colm]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic clear_board();
    for (int r = 0; r < BOARD_H; r++) board[r] = '0;
  endtask

  task automatic check_piece(input string tag);
    chk({tag, "_type"}, int'(bus.active_piece.ptype), m_type);
    chk({tag, "_rot"},  int'(bus.active_piece.rot), m_rot);
    chk({tag, "_x"},    int'($signed(bus.active_piece.x)), m_x);
    chk({tag, "_y"},    int'($signed(bus.active_piece.y)), m_y);
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [15:0] ap;
    ap = bus.active_piece;
    chk({tag, "_active"},   int'(ap), 0);
    chk({tag, "_pvalid"},   bus.piece_valid, 0);
    chk({tag, "_resp"},     bus.resp_valid, 0);
    chk({tag, "_acc"},      bus.resp_accepted, 0);
    chk({tag, "_lock"},     bus.lock_pulse, 0);
    chk({tag, "_gameover"}, bus.game_over, 0);
    chk({tag, "_addr"},     int'(bus.board_row_addr), 0);
    chk({tag, "_sready"},   bus.spawn_ready, 1);
    chk({tag, "_cready"},   bus.cmd_ready, 0);
  endtask

  // Issue one request at #1 after a clock edge, in IDLE. rst_at > 0 asserts
  // reset that many cycles after the accept edge instead of waiting for RESP.
  task automatic do_req(input bit is_spawn, input int arg, input int rst_at);
    int  ct, cr, cx, cy, n;
    bit  coll, acc, lock, go;
    if (is_spawn) begin
      ct = arg; cr = 0; cx = BOARD_W / 2 - 2; cy = 0;
      chk("spawn_ready", bus.spawn_ready, 1);
      coll = model_collide(ct, cr, cx, cy);
      bus.spawn_type  = piece_type_t'(3'(arg));
      bus.spawn_valid = 1'b1;
    end else begin
      ct = m_type; cr = m_rot; cx = m_x; cy = m_y;
      case (arg)
        0: cx = cx - 1;
        1: cx = cx + 1;
        2: cy = cy + 1;
        3: cr = (cr + 1) % 4;
        4: cr = (cr + 3) % 4;
        default: ;
      endcase
      chk("cmd_ready", bus.cmd_ready, 1);
      coll = (arg > 4) ? 1'b1 : model_collide(ct, cr, cx, cy);
      bus.cmd       = 3'(arg);
      bus.cmd_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus.spawn_valid = 1'b0;
    bus.cmd_valid   = 1'b0;

    for (n = 1; n <= 12; n++) begin
      if (n == rst_at) begin
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        m_type = 0; m_rot = 0; m_x = 0; m_y = 0; m_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(posedge clk); #1;
          chk("post_rst_resp", bus.resp_valid, 0);
          chk("post_rst_lock", bus.lock_pulse, 0);
        end
        chk("post_rst_sready", bus.spawn_ready, 1);
        return;
      end
      if (n <= 4 && (cy + n - 1) >= 0 && (cy + n - 1) < BOARD_H)
        chk("row_addr", int'(bus.board_row_addr), cy + n - 1);
      if (bus.resp_valid) break;
      @(posedge clk); #1;
    end
    chk("latency", n, 6);

    acc  = !coll;
    lock = !is_spawn && (arg == 2) && coll;
    go   = is_spawn && coll;
    chk("resp_accepted", bus.resp_accepted, int'(acc));
    chk("lock_pulse", bus.lock_pulse, int'(lock));
    chk("game_over", bus.game_over, int'(go));
    if (acc) begin
      m_type = ct; m_rot = cr; m_x = cx; m_y = cy;
      if (is_spawn) m_valid = 1'b1;
    end
    check_piece("resp_piece");
    chk("resp_pvalid", bus.piece_valid, int'(m_valid));
    if (lock) m_valid = 1'b0;

    @(posedge clk); #1;
    chk("resp_clear", bus.resp_valid, 0);
    chk("lock_clear", bus.lock_pulse, 0);
    chk("idle_pvalid", bus.piece_valid, int'(m_valid));
    chk("idle_sready", bus.spawn_ready, int'(!m_valid));
    chk("idle_cready", bus.cmd_ready, int'(m_valid));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r;
    reset           = 1'b1;
    bus.spawn_valid = 1'b0;
    bus.spawn_type  = PIECE_I;
    bus.cmd_valid   = 1'b0;
    bus.cmd         = 3'd0;
    clear_board();
    m_type = 0; m_rot = 0; m_x = 0; m_y = 0; m_valid = 1'b0;

    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Spawn T on an empty board
    do_req(1'b1, 2, 0);
    check_piece("spawn_t");

    // Walk left into the wall
    for (int i = 0; i < 4; i++) do_req(1'b0, 0, 0);
    chk("wall_x", m_x, 0);

    // DOWN onto a full row 2 locks the piece
    board[2] = '1;
    do_req(1'b0, 2, 0);
    chk("lock_model_valid", int'(m_valid), 0);
    clear_board();

    // Rotation wrap in both directions with an I at y=5
    do_req(1'b1, 0, 0);
    do_req(1'b0, 4, 0);
    for (int i = 0; i < 5; i++) do_req(1'b0, 2, 0);
    check_piece("i_r270");
    do_req(1'b0, 3, 0);
    chk("rot_cw_wrap", m_rot, 0);
    do_req(1'b0, 4, 0);
    chk("rot_ccw_wrap", m_rot, 3);
    for (int i = 0; i < 25 && m_valid; i++) do_req(1'b0, 2, 0);

    // Spawn into a full top: game over
    for (int i = 0; i < 4; i++) board[i] = '1;
    do_req(1'b1, 1, 0);
    clear_board();

    // Reserved command: rejected, no state change
    do_req(1'b1, 3, 0);
    do_req(1'b0, 6, 0);

    // Reset during CHK2 of a DOWN
    do_req(1'b0, 2, 3);
    do_req(1'b1, 2, 0);

    // Randomized play against the reference model
    for (int it = 0; it < 300; it++) begin
      if (!m_valid) begin
        if ($urandom_range(0, 3) == 0) begin
          clear_board();
          for (int row = 12; row < BOARD_H; row++)
            board[row] = BOARD_W'($urandom & $urandom);
          if ($urandom_range(0, 7) == 0) board[1] = BOARD_W'($urandom);
        end
        do_req(1'b1, $urandom_range(0, 6), 0);
        if (!m_valid) clear_board();
      end else begin
        r = $urandom_range(0, 9);
        if (r < 2)       do_req(1'b0, 0, 0);
        else if (r < 4)  do_req(1'b0, 1, 0);
        else if (r < 7)  do_req(1'b0, 2, 0);
        else if (r == 7) do_req(1'b0, 3, 0);
        else if (r == 8) do_req(1'b0, 4, 0);
        else             do_req(1'b0, $urandom_range(5, 7), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/piece_move_ctrl.md
Name: piece_move_ctrl

Overview:
- Owns the falling piece's state: position, rotation and type.
- Sequences spawn and move requests through a candidate-check pipeline:
  - builds a candidate active_piece_t;
  - decodes it with an internal piece_decoder instance;
  - reads 4 board rows from the synchronous board RAM and tests for collision;
  - commits the candidate or rejects it.
- Sits between the input/gravity logic (requesters) and the board/lock logic.

Parameters:
BOARD_W, 10, board width in columns
BOARD_H, 20, board height in rows

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
spawn_valid  in  1  request new piece
spawn_type  in  piece_type_t  type of the new piece
spawn_ready  out  1  spawn accepted when spawn_valid && spawn_ready
cmd_valid  in  1  move request
cmd  in  3  0=LEFT 1=RIGHT 2=DOWN 3=ROT_CW 4=ROT_CCW; 5-7 reserved
cmd_ready  out  1  cmd accepted when cmd_valid && cmd_ready
board_row_addr  out  5  board row read address
board_row_data  in  BOARD_W  row contents, 1-cycle read latency; bit i = column i
active_piece  out  active_piece_t  committed piece
piece_valid  out  1  active_piece holds a live piece
resp_valid  out  1  1-cycle pulse: request finished
resp_accepted  out  1  qualifies resp_valid: candidate committed
lock_pulse  out  1  1-cycle pulse: DOWN rejected, piece must lock
game_over  out  1  1-cycle pulse: spawn collided

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, active_piece all zero, piece_valid=0, resp_valid=0, resp_accepted=0, lock_pulse=0, game_over=0, board_row_addr=0.
- Reset asserted mid-check aborts the operation immediately; nothing is committed.
- Ready signals:
  - spawn_ready = (state==IDLE) && !piece_valid
  - cmd_ready = (state==IDLE) && piece_valid
  - They are mutually exclusive, so no arbitration is needed.
- Candidate formed at the accept edge and held in a register:
  - spawn: {spawn_type, ROT_0, x=BOARD_W/2-2, y=0}.
  - LEFT: x-1. RIGHT: x+1. DOWN: y+1.
  - ROT_CW: rotation+1 mod 4 (ROT_270 wraps to ROT_0).
  - ROT_CCW: rotation-1 mod 4 (ROT_0 wraps to ROT_270).
  - x and y are signed; arithmetic is done at the field width.
  - Reserved cmd: accepted, then resp_valid=1 with resp_accepted=0 after the normal latency; no state change.
- FSM: IDLE -> CHK0..CHK4 (5 cycles) -> RESP (1 cycle) -> IDLE.
  - In CHKk (k=0..3): board_row_addr = cand.y+k; the row data is evaluated in CHK(k+1).
  - board_row_addr is don't-care when row y+k is outside 0..BOARD_H-1.
  - The decision is registered at the CHK4->RESP edge.
- Collision: cand_grid.piece[r] bit c set maps to board column x+c, row y+r. The candidate collides if any set cell has:
  - column < 0 or column >= BOARD_W, or
  - row >= BOARD_H, or
  - the board bit at that cell is set.
  - Rows < 0 are treated as empty and never collide.
- RESP cycle:
  - resp_valid=1.
  - resp_accepted=!collision.
  - If accepted, active_piece already equals the candidate.
  - If rejected, active_piece is unchanged.
- Rejected DOWN:
  - lock_pulse=1 in RESP; active_piece still holds the pre-move position for sampling.
  - piece_valid clears at the RESP->IDLE edge.
- Rejected LEFT/RIGHT/ROT: no side effects.
- Spawn:
  - Accepted: piece_valid=1 from RESP onward.
  - Collided: game_over=1 in RESP; piece_valid stays 0; active_piece is unchanged.
- Latency: accept edge to resp_valid high = 6 cycles. Next request can be accepted in the 7th cycle; one request in flight maximum.

Test Plan:
- Spawn T on an empty board after reset -> board_row_addr 0,1,2,3 in CHK0..3; resp_valid/resp_accepted=1 in the 6th cycle; active_piece={T,ROT_0,3,0}; piece_valid=1; spawn_ready=0.
- From T{ROT_0,x=3}, issue LEFT x4 -> x=2,1,0 all accepted; 4th rejected (column -1), x=0, no lock_pulse.
- T{ROT_0,3,0}, board row 2 = 10'h3FF, issue DOWN -> resp_accepted=0, lock_pulse=1 with active_piece.y=0; piece_valid=0 next cycle; cmd_ready=0, spawn_ready=1.
- I{ROT_270,3,5}, empty board: ROT_CW -> rotation ROT_0 accepted; then ROT_CCW -> ROT_270 accepted.
- Board rows 0-3 = 10'h3FF, spawn O -> game_over=1 in RESP, resp_accepted=0, piece_valid=0.
- Assert reset during CHK2 of a DOWN -> all outputs at reset values asynchronously; after release, spawn_ready=1 and no resp_valid or lock_pulse appears.
